control_fsm_cpu: RTL and testbench

//  Multi-cycle control unit directly upstream of data_path_cpu. It consumes the datapath's opcode, funct,
//  is_alu_zero and is_full_rnum1/2, and drives every datapath control input.

---
 rtl/control_fsm_cpu.sv | 167 ++++++++++++++++
 tb/tb_control_fsm_cpu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/control_fsm_cpu.sv
// Multi-cycle control unit for data_path_cpu: sequences each instruction through
// IF/ID/EX/MEM/WB/BR, stalls in ID on register hazards and freezes on the halt opcode.
module control_fsm_cpu #(
  parameter logic [5:0]  HALT_OPCODE = 6'h3F,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       is_alu_zero,
  input  logic       is_full_rnum1,
  input  logic       is_full_rnum2,
  output logic       is_load_PC,
  output logic       is_write_reg,
  output logic       is_write_mem,
  output logic [5:0] opcode_alu,
  output logic       is_R_type,
  output logic       is_I_type,
  output logic       is_J_type,
  output logic       is_write_from_mem,
  output logic [1:0] control_mux_for_PC,
  output logic [2:0] state,
  output logic       is_halted,
  output logic       stall_error
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [7:0] LIMIT   = 8'(STALL_LIMIT);

  state_t     state_q, state_d;
  logic [5:0] ir_op, ir_funct;
  logic       z_q;
  logic [7:0] stall_cnt, cnt_inc;
  logic       stall_error_q;

  logic dec_r, dec_j, dec_beq, dec_addi, dec_lw, dec_sw, dec_halt;
  logic reads_rt, stall, in_body;

  // Halt takes priority so a HALT_OPCODE that aliases a real opcode still halts.
  assign dec_halt = (ir_op == HALT_OPCODE);
  assign dec_r    = !dec_halt && (ir_op == OP_R);
  assign dec_j    = !dec_halt && (ir_op == OP_J);
  assign dec_beq  = !dec_halt && (ir_op == OP_BEQ);
  assign dec_addi = !dec_halt && (ir_op == OP_ADDI);
  assign dec_lw   = !dec_halt && (ir_op == OP_LW);
  assign dec_sw   = !dec_halt && (ir_op == OP_SW);

  assign reads_rt = dec_r || dec_sw || dec_beq;
  assign stall    = is_full_rnum1 || (is_full_rnum2 && reads_rt);
  assign cnt_inc  = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
  assign in_body  = (state_q == S_ID) || (state_q == S_EX) || (state_q == S_MEM) ||
                    (state_q == S_WB) || (state_q == S_BR);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IF;
      ir_op         <= '0;
      ir_funct      <= '0;
      z_q           <= 1'b0;
      stall_cnt     <= '0;
      stall_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF) begin
        ir_op    <= opcode;
        ir_funct <= funct;
      end
      if (state_q == S_EX && dec_beq) z_q <= is_alu_zero;
      if (state_q == S_ID && stall) begin
        stall_cnt <= cnt_inc;
        if (cnt_inc >= LIMIT) stall_error_q <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = S_IF;
    unique case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (stall)                   state_d = S_ID;
        else if (dec_halt)           state_d = S_HALT;
        else if (dec_r || dec_addi || dec_lw || dec_sw || dec_beq)
                                     state_d = S_EX;
        else                         state_d = S_BR;
      end
      S_EX: begin
        if (dec_r || dec_addi)       state_d = S_WB;
        else if (dec_lw || dec_sw)   state_d = S_MEM;
        else if (dec_beq)            state_d = S_BR;
      end
      S_MEM:  state_d = dec_lw ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_BR:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    is_load_PC         = 1'b0;
    is_write_reg       = 1'b0;
    is_write_mem       = 1'b0;
    opcode_alu         = '0;
    is_R_type          = 1'b0;
    is_I_type          = 1'b0;
    is_J_type          = 1'b0;
    is_write_from_mem  = 1'b0;
    control_mux_for_PC = 2'd0;

    if (in_body) begin
      is_R_type         = dec_r;
      is_I_type         = dec_addi || dec_lw || dec_sw || dec_beq;
      is_J_type         = dec_j;
      is_write_from_mem = dec_lw;
      if (dec_r)                           opcode_alu = ir_funct;
      else if (dec_addi || dec_lw || dec_sw) opcode_alu = ALU_ADD;
      else if (dec_beq)                    opcode_alu = ALU_SUB;
    end

    case (state_q)
      S_WB: begin
        is_write_reg = 1'b1;
        is_load_PC   = 1'b1;
      end
      S_MEM: begin
        is_write_mem = dec_sw;
        is_load_PC   = dec_sw;
      end
      S_BR: begin
        is_load_PC = 1'b1;
        if (dec_j)               control_mux_for_PC = 2'd2;
        else if (dec_beq && z_q) control_mux_for_PC = 2'd1;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign is_halted   = (state_q == S_HALT);
  assign stall_error = stall_error_q;

endmodule

// File: tb/tb_control_fsm_cpu.sv
// Scoreboard bench for control_fsm_cpu: the driver queues the expected PC-update record
// per instruction, the monitor pops and compares it whenever is_load_PC strobes.
module tb_control_fsm_cpu;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       is_alu_zero, is_full_rnum1, is_full_rnum2;
  logic       is_load_PC, is_write_reg, is_write_mem;
  logic [5:0] opcode_alu;
  logic       is_R_type, is_I_type, is_J_type, is_write_from_mem;
  logic [1:0] control_mux_for_PC;
  logic [2:0] state;
  logic       is_halted, stall_error;

  control_fsm_cpu #(.HALT_OPCODE(6'h3F), .STALL_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .is_alu_zero(is_alu_zero), .is_full_rnum1(is_full_rnum1), .is_full_rnum2(is_full_rnum2),
    .is_load_PC(is_load_PC), .is_write_reg(is_write_reg), .is_write_mem(is_write_mem),
    .opcode_alu(opcode_alu), .is_R_type(is_R_type), .is_I_type(is_I_type),
    .is_J_type(is_J_type), .is_write_from_mem(is_write_from_mem),
    .control_mux_for_PC(control_mux_for_PC), .state(state),
    .is_halted(is_halted), .stall_error(stall_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lat;
    logic [1:0] mux;
    int         nwr;
    int         nmw;
    logic [5:0] alu;
    logic [2:0] cls;   // {R, I, J}
    logic       fm;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_cyc = 0, m_nwr = 0, m_nmw = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks cycles since IF and strobe counts, compares on each PC update.
  always @(negedge clk) begin
    if (rst) begin
      m_cyc = 0; m_nwr = 0; m_nmw = 0;
    end else begin
      if (state == 3'd0) begin
        m_cyc = 1; m_nwr = 0; m_nmw = 0;
      end else begin
        m_cyc++;
      end
      m_nwr += int'(is_write_reg);
      m_nmw += int'(is_write_mem);
      if (is_load_PC) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_load_pc: got strobe in state %0d expected none", state);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("latency",      m_cyc, e.lat);
          check("pc_mux",       control_mux_for_PC, e.mux);
          check("write_reg_n",  m_nwr, e.nwr);
          check("write_mem_n",  m_nmw, e.nmw);
          check("opcode_alu",   opcode_alu, e.alu);
          check("class_rij",    {is_R_type, is_I_type, is_J_type}, e.cls);
          check("wr_from_mem",  is_write_from_mem, e.fm);
          check("update_state", state, e.st);
        end
      end
    end
  end

  task automatic wait_if();
    int g = 0;
    while (state != 3'd0 && g < 50) begin
      @(negedge clk); g++;
    end
    if (state != 3'd0) check("wait_if_timeout", state, 0);
  endtask

  // Issue one instruction at an IF negedge; k = hazard cycles presented in ID,
  // on rs (rs=1) or rt (rs=0).
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int k, input bit rs, input bit push,
                       input int lat, input logic [1:0] mux, input int nwr, input int nmw,
                       input logic [5:0] alu, input logic [2:0] cls, input logic fm,
                       input logic [2:0] st);
    exp_t e;
    int   g = 0;
    int   kk = k;
    wait_if();
    opcode = op; funct = fn; is_alu_zero = z;
    is_full_rnum1 = 1'b0; is_full_rnum2 = 1'b0;
    if (push) begin
      e.lat = lat; e.mux = mux; e.nwr = nwr; e.nmw = nmw;
      e.alu = alu; e.cls = cls; e.fm = fm; e.st = st;
      sb.push_back(e);
    end
    @(negedge clk);
    while (state != 3'd0 && state != 3'd6 && g < 40) begin
      if (state == 3'd1) begin
        if (rs) is_full_rnum1 = (kk > 0);
        else    is_full_rnum2 = (kk > 0);
        if (kk > 0) kk--;
      end else begin
        is_full_rnum1 = 1'b0; is_full_rnum2 = 1'b0;
      end
      @(negedge clk); g++;
    end
    is_full_rnum1 = 1'b0; is_full_rnum2 = 1'b0;
    if (g >= 40) check("instr_timeout", state, 0);
  endtask

  function automatic logic [19:0] all_outs();
    return {is_load_PC, is_write_reg, is_write_mem, opcode_alu, is_R_type, is_I_type,
            is_J_type, is_write_from_mem, control_mux_for_PC, state, is_halted, stall_error};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; is_alu_zero = 1'b0;
    is_full_rnum1 = 1'b0; is_full_rnum2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst = 1'b0;

    //     op     fn     z  k  rs push lat mux wr mw alu    cls     fm st
    issue(6'h00, 6'h20, 0, 0, 0, 1,  4,  0, 1, 0, 6'h20, 3'b100, 0, 3'd4); // add
    issue(6'h23, 6'h00, 0, 0, 0, 1,  5,  0, 1, 0, 6'h20, 3'b010, 1, 3'd4); // lw
    issue(6'h2B, 6'h00, 0, 0, 0, 1,  4,  0, 0, 1, 6'h20, 3'b010, 0, 3'd3); // sw
    issue(6'h04, 6'h00, 1, 0, 0, 1,  4,  1, 0, 0, 6'h22, 3'b010, 0, 3'd5); // beq taken
    issue(6'h04, 6'h00, 0, 0, 0, 1,  4,  0, 0, 0, 6'h22, 3'b010, 0, 3'd5); // beq not taken
    issue(6'h02, 6'h00, 1, 0, 0, 1,  3,  2, 0, 0, 6'h00, 3'b001, 0, 3'd5); // j
    issue(6'h11, 6'h20, 0, 0, 0, 1,  3,  0, 0, 0, 6'h00, 3'b000, 0, 3'd5); // NOP
    issue(6'h00, 6'h22, 0, 3, 0, 1,  7,  0, 1, 0, 6'h22, 3'b100, 0, 3'd4); // sub, rt stall 3
    check("no_err_after_3", stall_error, 0);
    issue(6'h08, 6'h00, 0, 3, 0, 1,  4,  0, 1, 0, 6'h20, 3'b010, 0, 3'd4); // addi ignores rt
    issue(6'h23, 6'h00, 0, 2, 1, 1,  7,  0, 1, 0, 6'h20, 3'b010, 1, 3'd4); // lw, rs stall 2
    check("no_err_after_rs", stall_error, 0);
    issue(6'h2B, 6'h00, 0, 5, 0, 1,  9,  0, 0, 1, 6'h20, 3'b010, 0, 3'd3); // sw, rt stall 5
    check("err_after_5", stall_error, 1);
    issue(6'h00, 6'h25, 0, 0, 0, 1,  4,  0, 1, 0, 6'h25, 3'b100, 0, 3'd4); // or
    check("err_sticky", stall_error, 1);

    // Reset in the EX cycle of lw aborts it with no strobes.
    wait_if();
    opcode = 6'h23; funct = 6'h00;
    @(negedge clk);
    @(negedge clk);
    check("lw_in_ex", state, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ex_state", state, 0);
    check("rst_ex_strobes", {is_load_PC, is_write_reg, is_write_mem}, 0);
    check("rst_clears_err", stall_error, 0);
    rst = 1'b0;
    issue(6'h11, 6'h00, 0, 0, 0, 1,  3,  0, 0, 0, 6'h00, 3'b000, 0, 3'd5); // NOP after reset

    // Halt: parked until reset, no PC updates (the monitor flags any).
    issue(6'h3F, 6'h00, 0, 0, 0, 0,  0,  0, 0, 0, 6'h00, 3'b000, 0, 3'd0);
    check("halt_state", state, 6);
    check("halt_flag", is_halted, 1);
    repeat (5) @(negedge clk);
    check("halt_hold", {is_halted, state}, {1'b1, 3'd6});
    check("halt_no_strobe", {is_load_PC, is_write_reg, is_write_mem}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("halt_reset_outputs", all_outs(), 0);
    rst = 1'b0;
    issue(6'h00, 6'h20, 0, 0, 0, 1,  4,  0, 1, 0, 6'h20, 3'b100, 0, 3'd4); // add after halt

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
